// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the 5-stage core: merges EX redirects, ID/EX load-use
// hazards and multi-cycle MEM accesses into per-stage write enables and bubbles.
module pipeline_controller #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] next_pc_select,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       mem_req,
    input  logic       mem_ack,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       id_ex_write,
    output logic       ex_mem_write,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       mem_wb_flush,
    output logic       mem_error,
    output logic [1:0] ctrl_state
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t            state, state_nxt, eval_state;
    logic [2:0]        flush_cnt, flush_cnt_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              ret_flush, ret_flush_nxt;
    logic              redirect, load_use, mem_stall, evaluate, timeout;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            flush_cnt <= '0;
            wait_cnt  <= '0;
            ret_flush <= 1'b0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            wait_cnt  <= wait_cnt_nxt;
            ret_flush <= ret_flush_nxt;
        end
    end

    assign redirect  = (next_pc_select != 2'b00);
    assign load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                       ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                        (id_uses_rs2 && (id_rs2 == ex_rd)));
    assign mem_stall = mem_req && !mem_ack;

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_flush  = 1'b0;
        mem_error     = 1'b0;
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        wait_cnt_nxt  = wait_cnt;
        ret_flush_nxt = ret_flush;
        eval_state    = state;
        evaluate      = 1'b1;
        timeout       = 1'b0;

        // An ack or timeout in MEM_WAIT behaves exactly like the return state this cycle
        if (state == MEM_WAIT) begin
            eval_state = ret_flush ? FLUSH : RUN;
            if (!mem_ack) begin
                if (wait_cnt == TIMEOUT_V) begin
                    timeout = 1'b1;
                end else begin
                    evaluate     = 1'b0;
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    mem_wb_flush = 1'b1;
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
        end

        if (evaluate) begin
            if ((state != MEM_WAIT) && mem_stall) begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_write  = 1'b0;
                mem_wb_flush  = 1'b1;
                state_nxt     = MEM_WAIT;
                wait_cnt_nxt  = WAIT_W'(1);
                ret_flush_nxt = (state == FLUSH);
            end else if (eval_state == FLUSH) begin
                if_id_flush   = 1'b1;
                id_ex_flush   = 1'b1;
                flush_cnt_nxt = flush_cnt - 3'd1;
                state_nxt     = (flush_cnt == 3'd1) ? RUN : FLUSH;
            end else if (redirect) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = FLUSH_INIT;
                end else begin
                    state_nxt = RUN;
                end
            end else if (load_use) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                state_nxt   = RUN;
            end else begin
                state_nxt = RUN;
            end
        end

        // The abandoned access still retires as a bubble
        if (timeout) begin
            mem_error    = 1'b1;
            mem_wb_flush = 1'b1;
        end

        if (!reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
            mem_error    = 1'b0;
        end
    end

    assign ctrl_state = reset ? state : RUN;

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller: expected output vectors are queued as
// stimulus is applied and popped when the outputs are sampled on the falling edge.
module tb_pipeline_controller;

    typedef struct packed {
        logic [1:0] nps;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       req;
        logic       ack;
    } stim_t;

    // {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, mem_wb_flush, mem_error, ctrl_state}
    localparam logic [9:0] RST       = 10'b0000_111_0_00;
    localparam logic [9:0] RUN_DEF   = 10'b1111_000_0_00;
    localparam logic [9:0] RED       = 10'b1111_110_0_00;
    localparam logic [9:0] FL        = 10'b1111_110_0_01;
    localparam logic [9:0] LU        = 10'b0011_010_0_00;
    localparam logic [9:0] STALL_RUN = 10'b0000_001_0_00;
    localparam logic [9:0] STALL_FL  = 10'b0000_001_0_01;
    localparam logic [9:0] WAITV     = 10'b0000_001_0_10;
    localparam logic [9:0] ACK_RUN   = 10'b1111_000_0_10;
    localparam logic [9:0] ACK_RED   = 10'b1111_110_0_10;
    localparam logic [9:0] TMO       = 10'b1111_001_1_10;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] next_pc_select = '0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_read = 1'b0;
    logic       mem_req = 1'b0, mem_ack = 1'b0;

    logic       pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic       if_id_flush, id_ex_flush, mem_wb_flush, mem_error;
    logic [1:0] ctrl_state;
    logic       pc_write3, if_id_write3, id_ex_write3, ex_mem_write3;
    logic       if_id_flush3, id_ex_flush3, mem_wb_flush3, mem_error3;
    logic [1:0] ctrl_state3;
    logic [9:0] obs, obs3;

    logic [9:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipeline_controller #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(15)) u_dut (
        .clock(clock), .reset(reset), .next_pc_select(next_pc_select),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_flush(mem_wb_flush), .mem_error(mem_error), .ctrl_state(ctrl_state)
    );

    pipeline_controller #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(15)) u_dut3 (
        .clock(clock), .reset(reset), .next_pc_select(next_pc_select),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_write(pc_write3), .if_id_write(if_id_write3), .id_ex_write(id_ex_write3),
        .ex_mem_write(ex_mem_write3), .if_id_flush(if_id_flush3), .id_ex_flush(id_ex_flush3),
        .mem_wb_flush(mem_wb_flush3), .mem_error(mem_error3), .ctrl_state(ctrl_state3)
    );

    assign obs  = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                   if_id_flush, id_ex_flush, mem_wb_flush, mem_error, ctrl_state};
    assign obs3 = {pc_write3, if_id_write3, id_ex_write3, ex_mem_write3,
                   if_id_flush3, id_ex_flush3, mem_wb_flush3, mem_error3, ctrl_state3};

    task automatic apply(input stim_t s, input logic [9:0] e);
        @(posedge clock);
        #1;
        next_pc_select = s.nps;
        id_rs1         = s.rs1;
        id_rs2         = s.rs2;
        id_uses_rs1    = s.u1;
        id_uses_rs2    = s.u2;
        ex_rd          = s.rd;
        ex_mem_read    = s.mr;
        mem_req        = s.req;
        mem_ack        = s.ack;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        logic [9:0] e;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            reset          = 1'b0;
            next_pc_select = 2'($urandom_range(0, 3));
            id_rs1         = 5'($urandom_range(0, 31));
            id_rs2         = 5'($urandom_range(0, 31));
            id_uses_rs1    = 1'($urandom_range(0, 1));
            id_uses_rs2    = 1'($urandom_range(0, 1));
            ex_rd          = 5'($urandom_range(0, 31));
            ex_mem_read    = 1'($urandom_range(0, 1));
            mem_req        = 1'($urandom_range(0, 1));
            mem_ack        = 1'($urandom_range(0, 1));
            exp_q.push_back(RST);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset cycle %0d: got %b expected %b", i, obs, e);
            end
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        apply_quiet_now();
        exp_q.push_back(RUN_DEF);
        @(negedge clock);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset release: got %b expected %b", obs, e);
        end
    endtask

    task automatic apply_quiet_now();
        next_pc_select = '0;
        id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd = '0; ex_mem_read = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic test_redirect();
        stim_t st[$];
        logic [9:0] ex[$];
        stim_t s;
        logic [9:0] e;
        s = '0;
        for (int i = 0; i < 9; i++) begin st.push_back(s); ex.push_back(RUN_DEF); end
        s.nps = 2'b01; st.push_back(s); ex.push_back(RED);
        s.nps = 2'b10; st.push_back(s); ex.push_back(FL);
        s = '0;        st.push_back(s); ex.push_back(RUN_DEF);
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL redirect cycle %0d: got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t st[$];
        logic [9:0] ex[$];
        stim_t s;
        logic [9:0] e;
        s = '0; s.mr = 1'b1; s.rd = 5'd5; s.rs2 = 5'd5; s.u2 = 1'b1;
        st.push_back(s); ex.push_back(LU);
        s = '0; st.push_back(s); ex.push_back(RUN_DEF);
        s = '0; s.mr = 1'b1; s.rd = 5'd0; s.u1 = 1'b1; s.u2 = 1'b1;
        st.push_back(s); ex.push_back(RUN_DEF);
        s = '0; s.mr = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7; s.u1 = 1'b0;
        st.push_back(s); ex.push_back(RUN_DEF);
        s.u1 = 1'b1; st.push_back(s); ex.push_back(LU);
        s.mr = 1'b0; st.push_back(s); ex.push_back(RUN_DEF);
        s.mr = 1'b1; s.nps = 2'b11; st.push_back(s); ex.push_back(RED);
        s.nps = 2'b00; st.push_back(s); ex.push_back(FL);
        s = '0; st.push_back(s); ex.push_back(RUN_DEF);
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL load_use step %0d: got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_mem_wait();
        stim_t st[$];
        logic [9:0] ex[$];
        stim_t s;
        logic [9:0] e;
        s = '0; s.req = 1'b1;
        st.push_back(s); ex.push_back(STALL_RUN);
        for (int i = 0; i < 3; i++) begin st.push_back(s); ex.push_back(WAITV); end
        s.ack = 1'b1; st.push_back(s); ex.push_back(ACK_RUN);
        s = '0;       st.push_back(s); ex.push_back(RUN_DEF);
        s.req = 1'b1; s.ack = 1'b1; st.push_back(s); ex.push_back(RUN_DEF);
        s.ack = 1'b0; s.nps = 2'b01; st.push_back(s); ex.push_back(STALL_RUN);
        st.push_back(s); ex.push_back(WAITV);
        s.ack = 1'b1; st.push_back(s); ex.push_back(ACK_RED);
        s = '0;       st.push_back(s); ex.push_back(FL);
        st.push_back(s); ex.push_back(RUN_DEF);
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL mem_wait step %0d: got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_stall_in_flush();
        stim_t st[$];
        logic [9:0] ex[$];
        stim_t s;
        logic [9:0] e;
        int squash;
        squash = 0;
        s = '0;
        for (int i = 0; i < 4; i++) begin st.push_back(s); ex.push_back(RUN_DEF); end
        s.nps = 2'b01; st.push_back(s); ex.push_back(RED);
        s = '0; s.req = 1'b1; st.push_back(s); ex.push_back(STALL_FL);
        st.push_back(s); ex.push_back(WAITV);
        s.ack = 1'b1; st.push_back(s); ex.push_back(ACK_RED);
        s = '0; st.push_back(s); ex.push_back(FL);
        st.push_back(s); ex.push_back(RUN_DEF);
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i], ex[i]);
            @(negedge clock);
            if (if_id_flush3) squash++;
            e = exp_q.pop_front();
            checks++;
            if (obs3 !== e) begin
                errors++;
                $display("FAIL stall_in_flush step %0d: got %b expected %b", i, obs3, e);
            end
        end
        checks++;
        if (squash !== 3) begin
            errors++;
            $display("FAIL stall_in_flush squash count: got %0d expected 3", squash);
        end
    endtask

    task automatic test_timeout();
        stim_t s;
        logic [9:0] e;
        logic [9:0] want;
        int pulses;
        pulses = 0;
        for (int i = 0; i < 17; i++) begin
            s = '0;
            s.req = (i < 16);
            if (i == 0)       want = STALL_RUN;
            else if (i < 15)  want = WAITV;
            else if (i == 15) want = TMO;
            else              want = RUN_DEF;
            apply(s, want);
            @(negedge clock);
            if (mem_error) pulses++;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL timeout cycle %0d: got %b expected %b", i, obs, e);
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL timeout pulse count: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_reset_abort();
        stim_t s;
        logic [9:0] e;
        s = '0; s.nps = 2'b01;
        apply(s, RED);
        @(negedge clock);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_abort redirect: got %b expected %b", obs, e);
        end
        s = '0;
        apply(s, FL);
        @(negedge clock);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_abort flush: got %b expected %b", obs, e);
        end
        #1;
        reset = 1'b0;
        exp_q.push_back(RST);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_abort async: got %b expected %b", obs, e);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.push_back(RUN_DEF);
        @(negedge clock);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_abort release: got %b expected %b", obs, e);
        end
    endtask

    initial begin
        test_reset();
        test_redirect();
        test_load_use();
        test_mem_wait();
        test_stall_in_flush();
        test_timeout();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
